// File: rtl/cam_ctrl_pkg.sv
// Shared definitions for the CAM sequencer: default geometry, request opcodes
// and controller states.
package cam_ctrl_pkg;

  localparam int CAM_DEPTH  = 16;
  localparam int CAM_ADDR_W = 4;
  localparam int CAM_DATA_W = 8;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'd0,
    OP_SEARCH = 2'd1,
    OP_CLEAR  = 2'd2,
    OP_NOP    = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    INIT         = 3'd0,
    IDLE         = 3'd1,
    WRITE        = 3'd2,
    SEARCH_ISSUE = 3'd3,
    SEARCH_WAIT  = 3'd4,
    RESP         = 3'd5,
    CLEAR_SWEEP  = 3'd6
  } state_e;

endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-index priority encoder for the CAM match vector, with any-hit and
// more-than-one-hit flags.
module cam_prio_enc
  import cam_ctrl_pkg::*;
#(
  parameter int DEPTH  = CAM_DEPTH,
  parameter int ADDR_W = CAM_ADDR_W
) (
  input  logic [DEPTH-1:0]  match,
  output logic              found,
  output logic              multi,
  output logic [ADDR_W-1:0] addr
);

  logic [DEPTH-1:0] match_m1;
  logic [DEPTH-1:0] lowest;

  // Isolating the lowest set bit turns the encode into a plain one-hot OR.
  assign match_m1 = match - DEPTH'(1);
  assign lowest   = match & ~match_m1;
  assign found    = |match;
  assign multi    = |(match & match_m1);

  genvar gi;
  for (gi = 0; gi < ADDR_W; gi++) begin : g_addr_bit
    logic [DEPTH-1:0] sel;
    always_comb begin
      sel = '0;
      for (int i = 0; i < DEPTH; i++) begin
        sel[i] = 1'((i >> gi) & 1);
      end
    end
    assign addr[gi] = |(lowest & sel);
  end

endmodule

// File: rtl/cam_ctrl.sv
// CAM sequencer: zero sweep after reset, write/search/clear front-end and
// match encoding. CAM_VALID_BITS_EN adds a per-entry valid mask.
module cam_ctrl
  import cam_ctrl_pkg::*;
#(
  parameter int DEPTH  = CAM_DEPTH,
  parameter int ADDR_W = CAM_ADDR_W,
  parameter int DATA_W = CAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              resp_valid,
  output logic              resp_found,
  output logic              resp_multi,
  output logic [ADDR_W-1:0] resp_addr,
  output logic              busy,
  output logic              cam_we,
  output logic [ADDR_W-1:0] cam_waddr,
  output logic [DATA_W-1:0] cam_wdata,
  output logic              cam_search,
  output logic [DATA_W-1:0] cam_key,
  input  logic [DEPTH-1:0]  cam_match
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_found_q, resp_found_d;
  logic              resp_multi_q, resp_multi_d;
  logic [ADDR_W-1:0] resp_addr_q, resp_addr_d;
  logic              cam_we_q, cam_we_d;
  logic [ADDR_W-1:0] cam_waddr_q, cam_waddr_d;
  logic [DATA_W-1:0] cam_wdata_q, cam_wdata_d;
  logic              cam_search_q, cam_search_d;
  logic [DATA_W-1:0] cam_key_q, cam_key_d;

  logic [DEPTH-1:0]  match_eff;
  logic              enc_found, enc_multi;
  logic [ADDR_W-1:0] enc_addr;
  logic              accept;

`ifdef CAM_VALID_BITS_EN
  logic [DEPTH-1:0] valid_q, valid_d;

  // The write strobe is phase-aligned with the state: only WRITE carries user
  // data, every other visible write is a sweep that invalidates its entry.
  always_comb begin
    valid_d = valid_q;
    if (cam_we_q) begin
      valid_d[cam_waddr_q] = (state_q == WRITE);
    end
  end

  assign match_eff = cam_match & valid_q;
`else
  assign match_eff = cam_match;
`endif

  cam_prio_enc #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_prio_enc (
    .match (match_eff),
    .found (enc_found),
    .multi (enc_multi),
    .addr  (enc_addr)
  );

  assign accept = req_valid && req_ready_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_ready_d  = req_ready_q;
    busy_d       = busy_q;
    resp_valid_d = 1'b0;
    resp_found_d = 1'b0;
    resp_multi_d = 1'b0;
    resp_addr_d  = '0;
    cam_we_d     = 1'b0;
    cam_waddr_d  = cam_waddr_q;
    cam_wdata_d  = cam_wdata_q;
    cam_search_d = 1'b0;
    cam_key_d    = cam_key_q;

    case (state_q)
      INIT: begin
        req_ready_d = 1'b0;
        busy_d      = 1'b1;
        cam_we_d    = 1'b1;
        cam_waddr_d = cnt_q;
        cam_wdata_d = '0;
        cnt_d       = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
        end
      end

      IDLE: begin
        if (accept) begin
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          case (op_e'(req_op))
            OP_WRITE: begin
              cam_we_d     = 1'b1;
              cam_waddr_d  = req_addr;
              cam_wdata_d  = req_data;
              resp_valid_d = 1'b1;
              state_d      = WRITE;
            end
            OP_SEARCH: begin
              cam_search_d = 1'b1;
              cam_key_d    = req_data;
              state_d      = SEARCH_ISSUE;
            end
            OP_CLEAR: begin
              // Entry 0 goes out with the accept; the sweep continues from 1.
              cam_we_d    = 1'b1;
              cam_waddr_d = '0;
              cam_wdata_d = '0;
              cnt_d       = ADDR_W'(1);
              state_d     = CLEAR_SWEEP;
            end
            default: begin
              resp_valid_d = 1'b1;
              state_d      = RESP;
            end
          endcase
        end else begin
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
        end
      end

      WRITE, RESP: begin
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end

      SEARCH_ISSUE: begin
        state_d = SEARCH_WAIT;
      end

      SEARCH_WAIT: begin
        resp_valid_d = 1'b1;
        resp_found_d = enc_found;
        resp_multi_d = enc_multi;
        resp_addr_d  = enc_addr;
        req_ready_d  = 1'b1;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end

      CLEAR_SWEEP: begin
        // Counter wrapped back to 0 once the last entry has been written.
        if (cnt_q == '0) begin
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else begin
          cam_we_d    = 1'b1;
          cam_waddr_d = cnt_q;
          cam_wdata_d = '0;
          cnt_d       = cnt_q + ADDR_W'(1);
        end
      end

      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= INIT;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      busy_q       <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_found_q <= 1'b0;
      resp_multi_q <= 1'b0;
      resp_addr_q  <= '0;
      cam_we_q     <= 1'b0;
      cam_waddr_q  <= '0;
      cam_wdata_q  <= '0;
      cam_search_q <= 1'b0;
      cam_key_q    <= '0;
`ifdef CAM_VALID_BITS_EN
      valid_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      resp_found_q <= resp_found_d;
      resp_multi_q <= resp_multi_d;
      resp_addr_q  <= resp_addr_d;
      cam_we_q     <= cam_we_d;
      cam_waddr_q  <= cam_waddr_d;
      cam_wdata_q  <= cam_wdata_d;
      cam_search_q <= cam_search_d;
      cam_key_q    <= cam_key_d;
`ifdef CAM_VALID_BITS_EN
      valid_q      <= valid_d;
`endif
    end
  end

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_found = resp_found_q;
  assign resp_multi = resp_multi_q;
  assign resp_addr  = resp_addr_q;
  assign cam_we     = cam_we_q;
  assign cam_waddr  = cam_waddr_q;
  assign cam_wdata  = cam_wdata_q;
  assign cam_search = cam_search_q;
  assign cam_key    = cam_key_q;

endmodule

// File: tb/tb_cam_ctrl.sv
// Directed bench for cam_ctrl with a behavioural CAM and a response scoreboard;
// expectations follow CAM_VALID_BITS_EN when it is defined.
module tb_cam_ctrl;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam logic [1:0] OPW = 2'd0, OPS = 2'd1, OPC = 2'd2, OPN = 2'd3;
`ifdef CAM_VALID_BITS_EN
  localparam bit VB = 1'b1;
`else
  localparam bit VB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = 2'd0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic          resp_valid, resp_found, resp_multi, busy;
  logic [AW-1:0] resp_addr, cam_waddr;
  logic          cam_we, cam_search;
  logic [DW-1:0] cam_wdata, cam_key;
  logic [DEPTH-1:0] cam_match = '0;

  always #5 clk = ~clk;

  cam_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_found(resp_found), .resp_multi(resp_multi),
    .resp_addr(resp_addr), .busy(busy),
    .cam_we(cam_we), .cam_waddr(cam_waddr), .cam_wdata(cam_wdata),
    .cam_search(cam_search), .cam_key(cam_key), .cam_match(cam_match)
  );

  // Behavioural CAM: match vector valid the cycle after cam_search.
  logic [DW-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = 8'h5A;
  always @(posedge clk) begin
    if (cam_we) mem[cam_waddr] <= cam_wdata;
    for (int i = 0; i < DEPTH; i++) cam_match[i] <= cam_search && (mem[i] == cam_key);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    string         tag;
    logic          f;
    logic [AW-1:0] a;
    logic          m;
    int            due;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    exp_t e;
    chk("we_search_excl", 32'(cam_we & cam_search), 0);
    if (resp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'(resp_valid), 0);
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_latency"}, cyc, e.due);
        chk({e.tag, "_found"}, 32'(resp_found), 32'(e.f));
        chk({e.tag, "_addr"}, 32'(resp_addr), 32'(e.a));
        chk({e.tag, "_multi"}, 32'(resp_multi), 32'(e.m));
      end
    end else if (sb.size() != 0 && cyc > sb[0].due) begin
      chk({sb[0].tag, "_missing"}, 32'(resp_valid), 1);
      void'(sb.pop_front());
    end
  end

  task automatic send(input string tag, input logic [1:0] op, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic f, input logic [AW-1:0] ea,
                      input logic m, input int lat, input bit hold);
    int   t = 0;
    exp_t e;
    req_valid = 1'b1; req_op = op; req_addr = a; req_data = d;
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      chk({tag, "_accept_timeout"}, 32'(req_ready), 1);
      req_valid = 1'b0;
      return;
    end
    e.tag = tag; e.f = f; e.a = ea; e.m = m; e.due = cyc + lat;
    sb.push_back(e);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Called at the negedge where rst has just been released.
  task automatic sweep_check(input string tag);
    for (int k = 1; k <= DEPTH; k++) begin
      @(negedge clk);
      chk({tag, "_we"}, 32'(cam_we), 1);
      chk({tag, "_waddr"}, 32'(cam_waddr), k - 1);
      chk({tag, "_wdata"}, 32'(cam_wdata), 0);
      chk({tag, "_busy"}, 32'(busy), 1);
      chk({tag, "_ready_low"}, 32'(req_ready), 0);
    end
    @(negedge clk);
    chk({tag, "_ready_after"}, 32'(req_ready), 1);
    chk({tag, "_busy_after"}, 32'(busy), 0);
    chk({tag, "_we_after"}, 32'(cam_we), 0);
  endtask

  initial begin
    int t;
    // 1. Reset state and sweep
    repeat (2) @(negedge clk);
    chk("rst_we", 32'(cam_we), 0);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_resp", 32'(resp_valid), 0);
    chk("rst_search", 32'(cam_search), 0);
    rst = 1'b0;
    sweep_check("sweep1");

    // 2. Writes then searches
    send("w55_0",  OPW, 4'd0,  8'h55, 0, 0, 0, 1, 0);
    send("wAA_1",  OPW, 4'd1,  8'hAA, 0, 0, 0, 1, 0);
    send("w77_2",  OPW, 4'd2,  8'h77, 0, 0, 0, 1, 0);
    send("w33_15", OPW, 4'd15, 8'h33, 0, 0, 0, 1, 0);
    send("s55", OPS, 4'd0, 8'h55, 1, 4'd0,  0, 3, 0);
    send("sAA", OPS, 4'd0, 8'hAA, 1, 4'd1,  0, 3, 0);
    send("s77", OPS, 4'd0, 8'h77, 1, 4'd2,  0, 3, 0);
    send("s33", OPS, 4'd0, 8'h33, 1, 4'd15, 0, 3, 0);

    // 3. Miss and zero key
    send("sFF_miss", OPS, 4'd0, 8'hFF, 0, 4'd0, 0, 3, 0);
    if (VB) send("s00_vb", OPS, 4'd0, 8'h00, 0, 4'd0, 0, 3, 0);
    else    send("s00_raw", OPS, 4'd0, 8'h00, 1, 4'd3, 1, 3, 0);

    // 4. Overwrite and duplicates
    send("wCC_1",    OPW, 4'd1, 8'hCC, 0, 0,    0, 1, 0);
    send("sAA_gone", OPS, 4'd0, 8'hAA, 0, 4'd0, 0, 3, 0);
    send("sCC",      OPS, 4'd0, 8'hCC, 1, 4'd1, 0, 3, 0);
    send("w55_9",    OPW, 4'd9, 8'h55, 0, 0,    0, 1, 0);
    send("s55_dup",  OPS, 4'd0, 8'h55, 1, 4'd0, 1, 3, 0);
    drain();

    // 5. Reset in the SEARCH_WAIT cycle
    req_valid = 1'b1; req_op = OPS; req_data = 8'h77;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("rstmid_accept", 32'(req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_no_resp", 32'(resp_valid), 0);
    chk("rstmid_busy", 32'(busy), 1);
    chk("rstmid_ready", 32'(req_ready), 0);
    rst = 1'b0;
    sweep_check("sweep2");
    send("sCC_after_rst", OPS, 4'd0, 8'hCC, 0, 4'd0, 0, 3, 0);

    // 6. Back-to-back with req_valid held, then CLEAR
    send("b2b_w11", OPW, 4'd4, 8'h11, 0, 0,    0, 1, 1);
    send("b2b_s11", OPS, 4'd0, 8'h11, 1, 4'd4, 0, 3, 1);
    send("b2b_nop", OPN, 4'd0, 8'h00, 0, 4'd0, 0, 1, 1);
    send("b2b_w22", OPW, 4'd5, 8'h22, 0, 0,    0, 1, 1);
    send("b2b_s22", OPS, 4'd0, 8'h22, 1, 4'd5, 0, 3, 1);
    send("clear",   OPC, 4'd0, 8'h00, 0, 4'd0, 0, 17, 0);
    send("s11_cleared", OPS, 4'd0, 8'h11, 0, 4'd0, 0, 3, 0);
    if (VB) send("s00_clr_vb", OPS, 4'd0, 8'h00, 0, 4'd0, 0, 3, 0);
    else    send("s00_clr_raw", OPS, 4'd0, 8'h00, 1, 4'd0, 1, 3, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=still running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/cam_ctrl.md
Name: cam_ctrl

Overview:
Sequencer and command front-end for the 16-entry x 8-bit CAM array in the tt_um_top datapath.
- After reset it sweeps every CAM location to zero.
- It accepts one request at a time (write / search / clear) over a valid/ready handshake and drives the CAM write and search strobes.
- It priority-encodes the CAM match vector into a found/address response.
- The tt_um_top pin mux drives it in place of the manual per-address initialisation sequence.

Parameters:
DEPTH, 16, number of CAM entries (power of two, >=2)
ADDR_W, 4, log2(DEPTH)
DATA_W, 8, CAM word width

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  controller can accept; transfer when req_valid&&req_ready
req_op  in  2  0=WRITE, 1=SEARCH, 2=CLEAR, 3=reserved (treated as NOP: ack only)
req_addr  in  ADDR_W  write address (ignored for SEARCH/CLEAR)
req_data  in  DATA_W  write data or search key
resp_valid  out  1  one-cycle response pulse, no backpressure
resp_found  out  1  search hit (0 for non-search ops)
resp_multi  out  1  more than one entry matched
resp_addr  out  ADDR_W  lowest matching index (0 if no hit)
busy  out  1  high in any state other than IDLE
cam_we  out  1  CAM write strobe
cam_waddr  out  ADDR_W  CAM write address
cam_wdata  out  DATA_W  CAM write data
cam_search  out  1  CAM search strobe
cam_key  out  DATA_W  CAM search key
cam_match  in  DEPTH  per-entry match vector; valid the cycle after cam_search

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- All outputs are registered.
- Reset values: every output is 0, req_ready=0, busy=1. The state machine goes to INIT with the sweep counter at 0.
- INIT state:
  - Lasts DEPTH cycles.
  - Each cycle: cam_we=1, cam_waddr=counter, cam_wdata=0; counter increments.
  - After writing DEPTH-1 the counter wraps to 0 and the FSM enters IDLE.
  - No response is issued for the reset-triggered sweep.
- IDLE state: req_ready=1, busy=0. The request is captured on the handshake edge, after which req_ready drops.
- WRITE (request accepted in cycle N):
  - Cycle N+1: cam_we=1 with captured addr/data, and resp_valid=1 with found=0.
  - Cycle N+2: IDLE, req_ready=1.
- SEARCH (request accepted in cycle N):
  - Cycle N+1: cam_search=1, cam_key=data.
  - Cycle N+2: the match vector is sampled.
  - Cycle N+3: resp_valid=1 with found=|match, addr = lowest set bit, multi = (popcount>1). req_ready is also 1 in this cycle.
- CLEAR (request accepted in cycle N):
  - Full INIT sweep over cycles N+1 .. N+DEPTH.
  - resp_valid in cycle N+DEPTH+1, then IDLE.
- NOP: resp_valid in cycle N+1, then IDLE.
- Only one request is ever outstanding; req_valid while busy is simply not accepted. Requesters hold their request until accepted.
- Duplicate data may be written to several entries; search resolves to the lowest index and sets resp_multi.
- cam_we and cam_search are never high in the same cycle.
- rst in any state, including mid-sweep or mid-search:
  - Aborts the operation; no resp_valid is produced for the aborted request.
  - All outputs return to reset values and the FSM restarts INIT from address 0.
- FSM states: INIT, IDLE, WRITE, SEARCH_ISSUE, SEARCH_WAIT, RESP, CLEAR_SWEEP. INIT and CLEAR_SWEEP share the counter.

Optional Feature:
CAM_VALID_BITS_EN
- Defined:
  - The controller keeps a DEPTH-bit valid vector. It is cleared by reset and by the INIT/CLEAR sweep, and bit addr is set on WRITE.
  - cam_match is ANDed with the valid vector before encoding, so cleared entries never hit. For example, searching 0x00 after a clear reports found=0.
- Undefined:
  - There is no valid vector, and the raw cam_match is encoded.
  - Searching 0x00 after a clear reports found=1, addr=0, multi=1.

Decomposition:
- Package cam_ctrl_pkg:
  - op encodings (OP_WRITE, OP_SEARCH, OP_CLEAR, OP_NOP)
  - FSM state enum
  - DEPTH/ADDR_W/DATA_W defaults
- One sub-module, cam_prio_enc: combinational DEPTH-to-ADDR_W lowest-index priority encoder with found and multi outputs. It is instantiated once.

Test Plan:
1. Reset sweep: rst high 2 cycles then low -> cam_we high 16 consecutive cycles with waddr 0..15 and wdata 0; busy=1 throughout; req_ready=1 on the 17th cycle after rst falls.
2. Writes then searches:
   - Write 0x55@0, 0xAA@1, 0x77@2, 0x33@15.
   - Search each of the four values; a bench CAM model returns matches one cycle after cam_search.
   - Expected responses, each arriving 3 cycles after its accept: found=1 with addr 0, 1, 2, 15 respectively; multi=0.
3. Miss and zero key:
   - Search 0xFF -> found=0, addr=0.
   - Search 0x00 -> found=0 with CAM_VALID_BITS_EN; found=1, addr=3, multi=1 without it.
4. Overwrite and duplicates:
   - Write 0xCC@1, then search 0xAA -> found=0; search 0xCC -> found=1, addr=1.
   - Write 0x55@9, then search 0x55 -> addr=0, multi=1.
5. Reset mid-operation: assert rst in the SEARCH_WAIT cycle -> no resp_valid; a new 16-cycle sweep follows; a subsequent search for 0xCC -> found=0 (valid-bit build).
6. Handshake and CLEAR:
   - Hold req_valid high continuously across back-to-back requests -> exactly one accept per IDLE cycle; cam_we and cam_search never high together.
   - CLEAR -> resp_valid exactly 17 cycles after its accept.
